// File: rtl/sm_step_shaper.sv
// -----------------------------------------------------------------------------
// sm_step_shaper
//
// This is the output stage between TR_pulse and the external stepper-motor
// driver IC. It converts raw step requests into driver-pin waveforms that meet
// the driver's timing limits: enable settle time, direction setup time, and
// minimum step high and low times. It also keeps a signed count of the motor
// position and counts step requests that were dropped because the stage was
// still busy with the previous step.
//
// Optional feature: define SM_SOFT_LIMIT_EN to add soft position limits.
// This adds the inputs pos_lim_lo and pos_lim_hi and the output limit_hit.
// When a request would move the position beyond a limit, it is rejected in
// READY and limit_hit pulses for one cycle.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-low
//   drv_step       in   step request; each rising edge is one request
//   drv_dir        in   requested direction (1 = +1, 0 = -1)
//   drv_enable_SM  in   motor enable
//   pos_clr        in   synchronous clear of position (wins over a step)
//   pos_lim_lo     in   lower soft limit, signed     (SM_SOFT_LIMIT_EN only)
//   pos_lim_hi     in   upper soft limit, signed     (SM_SOFT_LIMIT_EN only)
//   limit_hit      out  1-cycle pulse on limit reject (SM_SOFT_LIMIT_EN only)
//   sm_step        out  step pin to driver
//   sm_dir         out  direction pin to driver
//   sm_en_n        out  driver enable, active-low
//   position       out  signed position, wraps modulo 2^POS_W
//   busy           out  high in DIR_SETUP / STEP_HI / STEP_LO
//   step_missed    out  1-cycle pulse when an enabled request is dropped
//   missed_cnt     out  dropped-request count, saturating at 255
// -----------------------------------------------------------------------------
module sm_step_shaper #(
  parameter int T_ENA_SETUP = 250,
  parameter int T_DIR_SETUP = 25,
  parameter int T_STEP_HIGH = 100,
  parameter int T_STEP_LOW  = 100,
  parameter int POS_W       = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    drv_step,
  input  logic                    drv_dir,
  input  logic                    drv_enable_SM,
  input  logic                    pos_clr,
`ifdef SM_SOFT_LIMIT_EN
  input  logic signed [POS_W-1:0] pos_lim_lo,
  input  logic signed [POS_W-1:0] pos_lim_hi,
  output logic                    limit_hit,
`endif
  output logic                    sm_step,
  output logic                    sm_dir,
  output logic                    sm_en_n,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    step_missed,
  output logic [7:0]              missed_cnt
);

  typedef enum logic [2:0] {
    S_DISABLED,
    S_ENA_WAIT,
    S_READY,
    S_DIR_SETUP,
    S_STEP_HI,
    S_STEP_LO
  } state_t;

  // Each timer is loaded with T-1 and the state is left when the timer reads 0.
  // As a result, the state lasts exactly T cycles.
  localparam logic [15:0] ENA_LOAD = 16'(T_ENA_SETUP - 1);
  localparam logic [15:0] DIR_LOAD = 16'(T_DIR_SETUP - 1);
  localparam logic [15:0] HI_LOAD  = 16'(T_STEP_HIGH - 1);
  localparam logic [15:0] LO_LOAD  = 16'(T_STEP_LOW - 1);

  localparam logic signed [POS_W-1:0] POS_PLUS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
  localparam logic signed [POS_W-1:0] POS_MINUS_ONE = {POS_W{1'b1}};

  state_t      state;
  logic [15:0] timer;
  logic        drv_step_d;

  logic req;
  logic not_ready;
  logic limit_block;
  logic accept;
  logic missed;
  logic timer_done;
  logic pos_inc;

  assign req        = drv_step & ~drv_step_d;
  assign timer_done = (timer == 16'd0);

  // These are the enabled, non-DISABLED, non-READY states. In these states a
  // request is dropped and counted.
  assign not_ready = (state == S_ENA_WAIT) || (state == S_DIR_SETUP) ||
                     (state == S_STEP_HI)  || (state == S_STEP_LO);

`ifdef SM_SOFT_LIMIT_EN
  assign limit_block = ( drv_dir && (position >= pos_lim_hi)) ||
                       (!drv_dir && (position <= pos_lim_lo));
`else
  assign limit_block = 1'b0;
`endif

  assign accept = drv_enable_SM && req && (state == S_READY) && !limit_block;
  assign missed = drv_enable_SM && req && not_ready;

  // The position moves on the same edge where sm_step rises. This happens in
  // two cases:
  //   - an accepted request with an unchanged direction, or
  //   - the end of direction setup.
  // In both cases sm_dir already holds the direction of travel.
  assign pos_inc = (accept && (drv_dir == sm_dir)) ||
                   (drv_enable_SM && (state == S_DIR_SETUP) && timer_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv_step_d <= 1'b0;
    end else begin
      drv_step_d <= drv_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_DISABLED;
      timer   <= 16'd0;
      sm_step <= 1'b0;
      sm_dir  <= 1'b0;
      sm_en_n <= 1'b1;
      busy    <= 1'b0;
`ifdef SM_SOFT_LIMIT_EN
      limit_hit <= 1'b0;
`endif
    end else begin
`ifdef SM_SOFT_LIMIT_EN
      limit_hit <= 1'b0;
`endif
      if (!drv_enable_SM) begin
        // Losing the enable aborts any step in progress. sm_dir is kept so
        // that the next request compares against what the driver last saw.
        state   <= S_DISABLED;
        timer   <= 16'd0;
        sm_step <= 1'b0;
        sm_en_n <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_DISABLED: begin
            state   <= S_ENA_WAIT;
            sm_en_n <= 1'b0;
            timer   <= ENA_LOAD;
          end
          S_ENA_WAIT: begin
            if (timer_done) state <= S_READY;
            else            timer <= timer - 16'd1;
          end
          S_READY: begin
            if (req) begin
              if (limit_block) begin
`ifdef SM_SOFT_LIMIT_EN
                limit_hit <= 1'b1;
`endif
              end else if (drv_dir == sm_dir) begin
                state   <= S_STEP_HI;
                sm_step <= 1'b1;
                busy    <= 1'b1;
                timer   <= HI_LOAD;
              end else begin
                state  <= S_DIR_SETUP;
                sm_dir <= drv_dir;
                busy   <= 1'b1;
                timer  <= DIR_LOAD;
              end
            end
          end
          S_DIR_SETUP: begin
            if (timer_done) begin
              state   <= S_STEP_HI;
              sm_step <= 1'b1;
              timer   <= HI_LOAD;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          S_STEP_HI: begin
            if (timer_done) begin
              state   <= S_STEP_LO;
              sm_step <= 1'b0;
              timer   <= LO_LOAD;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          S_STEP_LO: begin
            if (timer_done) begin
              state <= S_READY;
              busy  <= 1'b0;
            end else begin
              timer <= timer - 16'd1;
            end
          end
          default: begin
            state   <= S_DISABLED;
            timer   <= 16'd0;
            sm_step <= 1'b0;
            sm_en_n <= 1'b1;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Position counter. A clear takes priority over a simultaneous step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      position <= '0;
    end else if (pos_clr) begin
      position <= '0;
    end else if (pos_inc) begin
      position <= position + (sm_dir ? POS_PLUS_ONE : POS_MINUS_ONE);
    end
  end

  // Dropped-request reporting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_missed <= 1'b0;
      missed_cnt  <= 8'd0;
    end else begin
      step_missed <= missed;
      if (missed && (missed_cnt != 8'hFF)) begin
        missed_cnt <= missed_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sm_step_shaper.sv
module tb_sm_step_shaper;

  localparam int T_ENA = 250;
  localparam int T_DIR = 25;
  localparam int T_HI  = 100;
  localparam int T_LO  = 100;
  localparam int POS_W = 24;
  localparam longint FAR = -1000000;

  logic clk;
  logic rst;
  logic drv_step;
  logic drv_dir;
  logic drv_enable_SM;
  logic pos_clr;
  logic sm_step;
  logic sm_dir;
  logic sm_en_n;
  logic signed [POS_W-1:0] position;
  logic busy;
  logic step_missed;
  logic [7:0] missed_cnt;
`ifdef SM_SOFT_LIMIT_EN
  logic signed [POS_W-1:0] lim_lo;
  logic signed [POS_W-1:0] lim_hi;
  logic limit_hit;
  assign lim_lo = -24'sd3;
  assign lim_hi = 24'sd2;
`endif

  sm_step_shaper #(
    .T_ENA_SETUP(T_ENA),
    .T_DIR_SETUP(T_DIR),
    .T_STEP_HIGH(T_HI),
    .T_STEP_LOW (T_LO),
    .POS_W      (POS_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .drv_step     (drv_step),
    .drv_dir      (drv_dir),
    .drv_enable_SM(drv_enable_SM),
    .pos_clr      (pos_clr),
`ifdef SM_SOFT_LIMIT_EN
    .pos_lim_lo   (lim_lo),
    .pos_lim_hi   (lim_hi),
    .limit_hit    (limit_hit),
`endif
    .sm_step      (sm_step),
    .sm_dir       (sm_dir),
    .sm_en_n      (sm_en_n),
    .position     (position),
    .busy         (busy),
    .step_missed  (step_missed),
    .missed_cnt   (missed_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_compared   = 0;
  int n_mismatched = 0;
  bit chk_on       = 1'b0;

  task automatic check_value(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model.
  // The model tracks time as absolute edge numbers. An accepted request
  // schedules the following:
  //   - the edge where the step pin rises,
  //   - the window in which the pin stays high,
  //   - the edge from which the next request may be accepted.
  // ---------------------------------------------------------------------------
  longint cyc;
  longint ready_at;
  longint rise_at;
  longint acc_at;
  bit     m_en;
  bit     m_pend;
  bit     m_step_d;
  logic   m_en_n, m_dir, m_step, m_busy, m_missed, m_lhit;
  logic signed [POS_W-1:0] m_pos;
  int     m_mcnt;

  function automatic bit limit_blocks(input logic d);
`ifdef SM_SOFT_LIMIT_EN
    return (d && (m_pos >= lim_hi)) || (!d && (m_pos <= lim_lo));
`else
    return (d === 1'bx); // no limits in this build
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc = 0; ready_at = 0; rise_at = FAR; acc_at = FAR;
      m_en = 0; m_pend = 0; m_step_d = 0;
      m_en_n = 1; m_dir = 0; m_step = 0; m_busy = 0; m_missed = 0; m_lhit = 0;
      m_pos = '0; m_mcnt = 0;
    end else begin
      bit req;
      cyc++;
      req      = drv_step && !m_step_d;
      m_step_d = drv_step;
      m_missed = 0;
      m_lhit   = 0;
      if (!drv_enable_SM) begin
        m_en = 0; m_en_n = 1; rise_at = FAR; acc_at = FAR; m_pend = 0;
      end else if (!m_en) begin
        m_en = 1; m_en_n = 0; ready_at = cyc + T_ENA + 1;
      end else if (req) begin
        if (cyc < ready_at) begin
          m_missed = 1;
          if (m_mcnt < 255) m_mcnt++;
        end else if (limit_blocks(drv_dir)) begin
          m_lhit = 1;
        end else begin
          acc_at = cyc;
          if (drv_dir != m_dir) begin
            m_dir   = drv_dir;
            rise_at = cyc + T_DIR;
          end else begin
            rise_at = cyc;
          end
          ready_at = rise_at + T_HI + T_LO + 1;
          m_pend   = 1;
        end
      end
      if (m_pend && cyc == rise_at) begin
        m_pend = 0;
        m_pos  = m_dir ? m_pos + 24'sd1 : m_pos - 24'sd1;
      end
      if (pos_clr) m_pos = '0;
      m_step = (cyc >= rise_at) && (cyc < rise_at + T_HI);
      m_busy = (cyc >= acc_at) && (cyc < rise_at + T_HI + T_LO);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check_value("sm_step",     sm_step,     m_step);
      check_value("sm_dir",      sm_dir,      m_dir);
      check_value("sm_en_n",     sm_en_n,     m_en_n);
      check_value("position",    position,    m_pos);
      check_value("busy",        busy,        m_busy);
      check_value("step_missed", step_missed, m_missed);
      check_value("missed_cnt",  missed_cnt,  m_mcnt);
`ifdef SM_SOFT_LIMIT_EN
      check_value("limit_hit",   limit_hit,   m_lhit);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic pulse_req(input logic d, input logic clr);
    $display("req dir=%0d clr=%0d at edge %0d", d, clr, cyc + 1);
    drv_dir  = d;
    drv_step = 1'b1;
    pos_clr  = clr;
    @(negedge clk);
    drv_step = 1'b0;
    pos_clr  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_sm_step"},  sm_step,     0);
    check_value({tag, "_sm_dir"},   sm_dir,      0);
    check_value({tag, "_sm_en_n"},  sm_en_n,     1);
    check_value({tag, "_position"}, position,    0);
    check_value({tag, "_busy"},     busy,        0);
    check_value({tag, "_missed"},   step_missed, 0);
    check_value({tag, "_mcnt"},     missed_cnt,  0);
  endtask

  initial begin
    rst = 1'b0; drv_step = 1'b0; drv_dir = 1'b0; drv_enable_SM = 1'b0; pos_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst    = 1'b1;
    chk_on = 1'b1;

    // enable, early request dropped during enable settle
    @(negedge clk);
    drv_enable_SM = 1'b1;
    idle(99);
    pulse_req(1'b1, 1'b0);
    idle(300);

    // direction change then same-direction step, then reverse
    pulse_req(1'b1, 1'b0);
    idle(300);
    pulse_req(1'b1, 1'b0);
    idle(300);
    pulse_req(1'b0, 1'b0);
    idle(300);

    // disable in the middle of STEP_HI
    pulse_req(1'b0, 1'b0);
    idle(49);
    drv_enable_SM = 1'b0;
    idle(2);
    check_value("abort_sm_step", sm_step, 0);
    check_value("abort_sm_en_n", sm_en_n, 1);
    drv_enable_SM = 1'b1;
    idle(400);

    // clear coinciding with the step edge
    pulse_req(1'b0, 1'b1);
    idle(300);

    // requests every 150 cycles: every second one is dropped
    for (int i = 0; i < 6; i++) begin
      pulse_req(1'b1, 1'b0);
      idle(149);
    end
    idle(300);

    // hammer requests until the dropped counter saturates
    for (int i = 0; i < 700; i++) begin
      drv_step = 1'b1;
      @(negedge clk);
      drv_step = 1'b0;
      @(negedge clk);
    end
    check_value("mcnt_saturated", missed_cnt, 255);
    $display("burst done: missed_cnt=%0d position=%0d", missed_cnt, position);

    // asynchronous reset in the middle of a step
    pulse_req(~drv_dir, 1'b0);
    idle(30);
    #3 rst = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      drv_step = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) drv_dir = ~drv_dir;
      pos_clr = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 2999) == 0) drv_enable_SM = 1'b0;
      else if (!drv_enable_SM && $urandom_range(0, 9) == 0) drv_enable_SM = 1'b1;
    end
    idle(2);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
